fifo_1r1w_large_status: RTL and testbench

- Parametrised successor to the team's large 1r1w ready/valid-in, valid/yumi-out FIFO.
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and support for non-power-of-two depth.
- Sits between producer and consumer pipelines that need early back-pressure or need to drain or discard queued traffic.

---
 rtl/fifo_status_pkg.sv | 13 +
 rtl/fifo_1r1w_large_status_if.sv | 10 +
 rtl/fifo_1r1w_status_mem.sv | 17 +
 rtl/fifo_1r1w_large_status.sv | 54 +++++
 tb/tb_fifo_1r1w_large_status.sv | 117 +++++++++++
 5 files changed

// File: rtl/fifo_status_pkg.sv
// fifo_status_pkg: width helpers and pointer wrap shared by the status FIFO family
package fifo_status_pkg;
  function automatic int ptr_w(int els);
    return $clog2(els) > 1 ? $clog2(els) : 1;
  endfunction
  function automatic int cnt_w(int els);
    return $clog2(els + 1);
  endfunction
  // Explicit wrap compare so non-power-of-two depths work.
  function automatic int unsigned ptr_incr(int unsigned p, int unsigned els);
    return p == els - 1 ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/fifo_1r1w_large_status_if.sv
// fifo_1r1w_large_status_if: producer/consumer/flush/status bundle; master drives v_i/data_i/yumi_i/flush_i, slave (FIFO) drives the rest
interface fifo_1r1w_large_status_if #(parameter int width_p = 8, parameter int els_p = 16);
  logic flush_i, v_i, ready_o, v_o, yumi_i, almost_full_o, almost_empty_o;
  logic [width_p-1:0] data_i, data_o;
  logic [fifo_status_pkg::cnt_w(els_p)-1:0] count_o;
  modport master(output flush_i, v_i, data_i, yumi_i,
                 input ready_o, v_o, data_o, count_o, almost_full_o, almost_empty_o);
  modport slave(input flush_i, v_i, data_i, yumi_i,
                output ready_o, v_o, data_o, count_o, almost_full_o, almost_empty_o);
endinterface

// File: rtl/fifo_1r1w_status_mem.sv
// fifo_1r1w_status_mem: els_p x width_p register file, one sync write port (w_*), one async read port (r_*)
module fifo_1r1w_status_mem import fifo_status_pkg::*; #(
  parameter int width_p = 8,
  parameter int els_p = 16
) (
  input  logic                        clk_i,
  input  logic                        w_v_i,
  input  logic [ptr_w(els_p)-1:0]     w_addr_i,
  input  logic [width_p-1:0]          w_data_i,
  input  logic [ptr_w(els_p)-1:0]     r_addr_i,
  output logic [width_p-1:0]          r_data_o
);
  logic [width_p-1:0] mem [els_p];
  always_ff @(posedge clk_i)
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/fifo_1r1w_large_status.sv
// fifo_1r1w_large_status: ready/valid-in, valid/yumi-out FIFO with count, almost flags, flush; ports clk_i, reset_n_i (sync active-low), f (slave bundle)
module fifo_1r1w_large_status import fifo_status_pkg::*; #(
  parameter int width_p = 8,
  parameter int els_p = 16,
  parameter int almost_full_p = 14,
  parameter int almost_empty_p = 2
) (
  input logic clk_i,
  input logic reset_n_i,
  fifo_1r1w_large_status_if.slave f
);
  localparam int pw = ptr_w(els_p);
  localparam int cw = cnt_w(els_p);
  localparam logic [cw-1:0] els_c = cw'(els_p);
  localparam logic [cw-1:0] af_c = cw'(almost_full_p);
  localparam logic [cw-1:0] ae_c = cw'(almost_empty_p);
  if (almost_full_p <= almost_empty_p) begin : g_bad_flags
    $error("almost_full_p must exceed almost_empty_p");
  end
  if (els_p < 2) begin : g_bad_els
    $error("els_p must be at least 2");
  end
  logic [pw-1:0] wptr, rptr;
  logic [cw-1:0] count;
  logic enq, deq;
  assign f.ready_o = reset_n_i & ~f.flush_i & (count != els_c);
  assign enq = f.v_i & f.ready_o;
  assign deq = f.yumi_i;
  // Outputs are forced to their reset values while reset is held, not just after the edge.
  assign f.v_o = reset_n_i & (count != '0);
  assign f.count_o = reset_n_i ? count : '0;
  assign f.almost_full_o = reset_n_i & (count >= af_c);
  assign f.almost_empty_o = ~reset_n_i | (count <= ae_c);
  always_ff @(posedge clk_i)
    if (!reset_n_i || f.flush_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= pw'(ptr_incr(32'(wptr), els_p));
      if (deq) rptr <= pw'(ptr_incr(32'(rptr), els_p));
      count <= count + cw'(enq) - cw'(deq);
    end
  fifo_1r1w_status_mem #(.width_p(width_p), .els_p(els_p)) mem (
    .clk_i(clk_i),
    .w_v_i(enq),
    .w_addr_i(wptr),
    .w_data_i(f.data_i),
    .r_addr_i(rptr),
    .r_data_o(f.data_o)
  );
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(f.yumi_i && !f.v_o));
  a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown({f.v_i, f.yumi_i}));
endmodule

// File: tb/tb_fifo_1r1w_large_status.sv
// tb_fifo_1r1w_large_status: queue-model checker with directed scenarios and random traffic
module tb_fifo_1r1w_large_status;
  localparam int W = 8, ELS = 5, AF = 4, AE = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  fifo_1r1w_large_status_if #(.width_p(W), .els_p(ELS)) f();
  fifo_1r1w_large_status #(.width_p(W), .els_p(ELS), .almost_full_p(AF), .almost_empty_p(AE)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .f(f)
  );
  int checks = 0, failures = 0;
  logic [W-1:0] q[$];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n || f.flush_i) q.delete();
    else begin
      int n;
      n = q.size();
      if (f.yumi_i && n != 0) void'(q.pop_front());
      if (f.v_i && n != ELS) q.push_back(f.data_i);
    end
  end
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("ready_o", 32'(f.ready_o), 32'(rst_n && !f.flush_i && n != ELS));
    chk("v_o", 32'(f.v_o), 32'(rst_n && n != 0));
    chk("count_o", 32'(f.count_o), rst_n ? 32'(n) : 0);
    chk("almost_full_o", 32'(f.almost_full_o), 32'(rst_n && n >= AF));
    chk("almost_empty_o", 32'(f.almost_empty_o), 32'(!rst_n || n <= AE));
    if (rst_n && n != 0) chk("data_o", 32'(f.data_o), 32'(q[0]));
  end
  task automatic cyc(logic v, logic [W-1:0] d, logic y, logic fl, logic rn);
    f.v_i = v;
    f.data_i = d;
    f.yumi_i = y;
    f.flush_i = fl;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask
  initial begin
    f.v_i = 0;
    f.data_i = 0;
    f.yumi_i = 0;
    f.flush_i = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_ready", 32'(f.ready_o), 0);
    chk("rst_count", 32'(f.count_o), 0);
    chk("rst_ae", 32'(f.almost_empty_o), 1);
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i * 'h11), 0, 0, 1);
    chk("full_ready", 32'(f.ready_o), 0);
    chk("full_count", 32'(f.count_o), 5);
    chk("full_af", 32'(f.almost_full_o), 1);
    for (int i = 1; i <= 5; i++) begin
      chk("drain_data", 32'(f.data_o), 32'(i * 'h11));
      cyc(0, 0, 1, 0, 1);
    end
    chk("drained_v", 32'(f.v_o), 0);
    cyc(1, 8'h80, 0, 0, 1);
    cyc(1, 8'h81, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h82 + i), 1, 0, 1);
    chk("steady_count", 32'(f.count_o), 2);
    chk("steady_head", 32'(f.data_o), 32'h94);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 1);
    chk("refill_count", 32'(f.count_o), 5);
    cyc(1, 8'hEE, 1, 0, 1);
    chk("full_rw_count", 32'(f.count_o), 4);
    chk("full_rw_ready", 32'(f.ready_o), 1);
    chk("full_rw_head", 32'(f.data_o), 32'h95);
    cyc(0, 0, 1, 0, 1);
    chk("pre_flush_count", 32'(f.count_o), 3);
    cyc(1, 8'h77, 1, 1, 1);
    chk("flush_count", 32'(f.count_o), 0);
    chk("flush_v", 32'(f.v_o), 0);
    chk("flush_ae", 32'(f.almost_empty_o), 1);
    cyc(1, 8'hA5, 0, 0, 1);
    chk("post_flush_v", 32'(f.v_o), 1);
    chk("post_flush_data", 32'(f.data_o), 32'hA5);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hB0 + i), 0, 0, 1);
    chk("pre_reset_count", 32'(f.count_o), 4);
    cyc(0, 0, 0, 0, 0);
    chk("mid_reset_count", 32'(f.count_o), 0);
    chk("mid_reset_ready", 32'(f.ready_o), 0);
    rst_n = 1;
    #1;
    chk("post_reset_ready", 32'(f.ready_o), 1);
    chk("post_reset_v", 32'(f.v_o), 0);
    cyc(1, 8'h3C, 0, 0, 1);
    chk("single_v", 32'(f.v_o), 1);
    chk("single_data", 32'(f.data_o), 32'h3C);
    chk("single_ae", 32'(f.almost_empty_o), 1);
    cyc(1, 8'h3D, 0, 0, 1);
    chk("two_ae", 32'(f.almost_empty_o), 1);
    cyc(1, 8'h3E, 0, 0, 1);
    chk("three_ae", 32'(f.almost_empty_o), 0);
    for (int i = 0; i < 3000; i++) begin
      logic rn, fl, v, y;
      rn = $urandom_range(0, 199) != 0;
      fl = $urandom_range(0, 49) == 0;
      v = $urandom_range(0, 99) < 60;
      y = rn && q.size() != 0 && $urandom_range(0, 99) < 50;
      cyc(v, 8'($urandom), y, fl, rn);
    end
    cyc(0, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
